// File: rtl/vga_pkg.sv
// Shared types for the VRAM port arbiter: slot decode and write-buffer entry.
package vga_pkg;

    // Default geometry of the VRAM macro this arbiter fronts.
    localparam int unsigned ADDR_W_DFLT = 17;
    localparam int unsigned DATA_W_DFLT = 8;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_SCAN  = 2'd1,
        SLOT_DRAIN = 2'd2
    } arb_slot_e;

    // Write-buffer entry at the default geometry; the arbiter re-declares it
    // at its own widths when instantiating the FIFO.
    typedef struct packed {
        logic [ADDR_W_DFLT-1:0] addr;
        logic [DATA_W_DFLT-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write-buffer FIFO; pointers wrap modulo DEPTH (power of two),
// occupancy is tracked by a separate 0..DEPTH counter. Reset empties it.
module vram_wr_fifo
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = wbuf_entry_t
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               do_push, do_pop;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: scanout reads always win, buffered writes drain on
// free cycles. Optional statistics outputs under VRAM_ARB_STATS_EN.
module vram_port_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DFLT,
    parameter int unsigned DATA_W       = DATA_W_DFLT,
    parameter int unsigned WBUF_DEPTH   = 8,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 1024
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          scan_req,
    input  logic [ADDR_W-1:0]             scan_addr,
    output logic                          scan_rvalid,
    output logic [DATA_W-1:0]             scan_rdata,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_level,
    output logic                          starve_err,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
`ifdef VRAM_ARB_STATS_EN
    output logic [31:0]                   stat_writes,
    output logic [$clog2(WBUF_DEPTH):0]   stat_peak_level,
`endif
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int unsigned STALL_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    arb_slot_e                   slot;
    entry_t                      push_entry, head_entry;
    logic                        fifo_full, fifo_empty, push, pop;
    logic [$clog2(WBUF_DEPTH):0] level;

    logic                        mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]           mem_wdata_q, mem_wdata_d;
    logic [MEM_LATENCY:0]        tag_q, tag_d;
    logic [STALL_W-1:0]          stall_q, stall_d;
    logic                        starve_q, starve_d;

    // Ready is forced low while reset is asserted so nothing is offered then.
    assign wr_ready   = !reset && !fifo_full;
    assign push       = wr_valid && wr_ready;
    assign pop        = (slot == SLOT_DRAIN);
    assign push_entry = '{addr: wr_addr, data: wr_data};

    vram_wr_fifo #(
        .DEPTH   (WBUF_DEPTH),
        .entry_t (entry_t)
    ) u_wr_fifo (
        .clk_in    (clk_in),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // Slot decision: scan beats drain, drain beats idle.
    always_comb begin
        slot = SLOT_IDLE;
        if (scan_req)         slot = SLOT_SCAN;
        else if (!fifo_empty) slot = SLOT_DRAIN;
    end

    // Next RAM port command from the slot.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        unique case (slot)
            SLOT_SCAN: begin
                mem_en_d   = 1'b1;
                mem_addr_d = scan_addr;
            end
            SLOT_DRAIN: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = head_entry.addr;
                mem_wdata_d = head_entry.data;
            end
            default: ;
        endcase
    end

    // Read-tag pipeline plus starvation counter and sticky error.
    always_comb begin
        tag_d    = {tag_q[MEM_LATENCY-1:0], slot == SLOT_SCAN};
        stall_d  = stall_q;
        if (fifo_empty || slot == SLOT_DRAIN) begin
            stall_d = '0;
        end else if (stall_q != STALL_W'(STARVE_LIMIT)) begin
            stall_d = stall_q + STALL_W'(1);
        end
        starve_d = starve_q || (stall_d == STALL_W'(STARVE_LIMIT));
    end

    // Port, tag and starvation registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag_q       <= '0;
            stall_q     <= '0;
            starve_q    <= 1'b0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag_q       <= tag_d;
            stall_q     <= stall_d;
            starve_q    <= starve_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wbuf_level  = level;
    assign starve_err  = starve_q;
    // Reset also hides a read that was already in flight.
    assign scan_rvalid = !reset && tag_q[MEM_LATENCY];
    assign scan_rdata  = scan_rvalid ? mem_rdata : '0;

`ifdef VRAM_ARB_STATS_EN
    logic [31:0]                 writes_q, writes_d;
    logic [$clog2(WBUF_DEPTH):0] peak_q, peak_d;

    // Drained-write count and occupancy high-water mark.
    always_comb begin
        writes_d = writes_q + 32'(pop);
        peak_d   = (level > peak_q) ? level : peak_q;
    end

    // Statistics registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            writes_q <= '0;
            peak_q   <= '0;
        end else begin
            writes_q <= writes_d;
            peak_q   <= peak_d;
        end
    end

    assign stat_writes     = writes_q;
    assign stat_peak_level = peak_q;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter: vector table for fill/drain/full
// cases, hand sequences for read latency, starvation and mid-flight reset.
module tb_vram_port_arbiter;

    localparam int unsigned LIMIT = 16;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        scan_req;
    logic [16:0] scan_addr;
    logic        scan_rvalid;
    logic [7:0]  scan_rdata;
    logic        wr_valid;
    logic        wr_ready;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic [3:0]  wbuf_level;
    logic        starve_err;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
`ifdef VRAM_ARB_STATS_EN
    logic [31:0] stat_writes;
    logic [3:0]  stat_peak_level;
`endif

    always #5 clk_in = ~clk_in;

    vram_port_arbiter #(
        .ADDR_W       (17),
        .DATA_W       (8),
        .WBUF_DEPTH   (8),
        .MEM_LATENCY  (1),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .scan_req        (scan_req),
        .scan_addr       (scan_addr),
        .scan_rvalid     (scan_rvalid),
        .scan_rdata      (scan_rdata),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wbuf_level      (wbuf_level),
        .starve_err      (starve_err),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
`ifdef VRAM_ARB_STATS_EN
        .stat_writes     (stat_writes),
        .stat_peak_level (stat_peak_level),
`endif
        .mem_rdata       (mem_rdata)
    );

    // Background RAM contents before any write.
    function automatic logic [7:0] pat(input logic [16:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Single-port RAM model, read latency 1.
    logic [7:0] ram     [0:131071];
    bit         wr_seen [0:131071];
    always @(posedge clk_in) begin
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) begin
                ram[mem_addr]     <= mem_wdata;
                wr_seen[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= wr_seen[mem_addr] ? ram[mem_addr] : pat(mem_addr);
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        scan_req  = 1'b0;
        scan_addr = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        scan;
        logic [16:0] saddr;
        logic        wv;
        logic [16:0] waddr;
        logic [7:0]  wdata;
        logic        en;
        logic        we;
        logic [16:0] addr;
        logic [7:0]  wd;
        logic [3:0]  lvl;
        logic        rdy;
        logic        rv;
        logic [7:0]  rd;
    } vec_t;

    vec_t        vecs[$];
    logic        prev_scan;
    logic [16:0] prev_saddr;

    // Expected read return trails the scan request by one table row.
    task automatic add(input logic scan, input logic [16:0] saddr, input logic wv,
                       input logic [16:0] waddr, input logic [7:0] wdata, input logic en,
                       input logic we, input logic [16:0] addr, input logic [7:0] wd,
                       input int lvl, input logic rdy);
        vec_t v;
        v.scan  = scan;  v.saddr = saddr; v.wv = wv; v.waddr = waddr; v.wdata = wdata;
        v.en    = en;    v.we    = we;    v.addr = addr; v.wd = wd;
        v.lvl   = 4'(lvl);
        v.rdy   = rdy;
        v.rv    = prev_scan;
        v.rd    = prev_scan ? pat(prev_saddr) : 8'h00;
        vecs.push_back(v);
        prev_scan  = scan;
        prev_saddr = saddr;
    endtask

    initial begin
        prev_scan  = 1'b0;
        prev_saddr = '0;
        // Fill 8 + one refused push under continuous scan.
        for (int i = 0; i < 9; i++)
            add(1'b1, 17'h40 + 17'(i), 1'b1, 17'h2000 + 17'(i), 8'hA0 + 8'(i),
                1'b1, 1'b0, 17'h40 + 17'(i), 8'h00, (i < 8) ? i + 1 : 8, i < 7);
        // Scan drops: eight drains in order, then idle.
        for (int j = 0; j < 8; j++)
            add(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 17'h2000 + 17'(j), 8'hA0 + 8'(j),
                7 - j, 1'b1);
        add(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 0, 1'b1);
        // Full buffer: drain refuses the push, next (scan) cycle takes it.
        for (int i = 0; i < 8; i++)
            add(1'b1, 17'h80 + 17'(i), 1'b1, 17'h3000 + 17'(i), 8'hC0 + 8'(i),
                1'b1, 1'b0, 17'h80 + 17'(i), 8'h00, i + 1, i < 7);
        add(1'b0, '0, 1'b1, 17'h3008, 8'hC8, 1'b1, 1'b1, 17'h3000, 8'hC0, 7, 1'b1);
        add(1'b1, 17'h90, 1'b1, 17'h3008, 8'hC8, 1'b1, 1'b0, 17'h90, 8'h00, 8, 1'b0);
        for (int j = 1; j < 9; j++)
            add(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 17'h3000 + 17'(j), 8'hC0 + 8'(j),
                8 - j, 1'b1);
        add(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 0, 1'b1);

        // Reset values.
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("rst mem_en", 32'(mem_en), 0);
        check("rst mem_we", 32'(mem_we), 0);
        check("rst mem_addr", 32'(mem_addr), 0);
        check("rst level", 32'(wbuf_level), 0);
        check("rst rvalid", 32'(scan_rvalid), 0);
        check("rst starve", 32'(starve_err), 0);
        check("rst wr_ready", 32'(wr_ready), 0);
        reset = 1'b0;
        #1;
        check("post-rst wr_ready", 32'(wr_ready), 1);

        // Vector table.
        for (int k = 0; k < vecs.size(); k++) begin
            scan_req  = vecs[k].scan;
            scan_addr = vecs[k].saddr;
            wr_valid  = vecs[k].wv;
            wr_addr   = vecs[k].waddr;
            wr_data   = vecs[k].wdata;
            tick();
            check($sformatf("v%0d mem_en", k), 32'(mem_en), 32'(vecs[k].en));
            check($sformatf("v%0d mem_we", k), 32'(mem_we), 32'(vecs[k].we));
            if (vecs[k].en) check($sformatf("v%0d mem_addr", k), 32'(mem_addr), 32'(vecs[k].addr));
            if (vecs[k].we) check($sformatf("v%0d mem_wdata", k), 32'(mem_wdata), 32'(vecs[k].wd));
            check($sformatf("v%0d level", k), 32'(wbuf_level), 32'(vecs[k].lvl));
            check($sformatf("v%0d wr_ready", k), 32'(wr_ready), 32'(vecs[k].rdy));
            check($sformatf("v%0d rvalid", k), 32'(scan_rvalid), 32'(vecs[k].rv));
            check($sformatf("v%0d rdata", k), 32'(scan_rdata), 32'(vecs[k].rd));
        end
        idle_inputs();

        // Back-to-back scan reads: address next cycle, data one cycle later.
        do_reset();
        repeat (8) tick();
        scan_req  = 1'b1;
        scan_addr = 17'h100;
        tick();
        check("lat a0 mem_en", 32'(mem_en), 1);
        check("lat a0 mem_addr", 32'(mem_addr), 32'h100);
        check("lat a0 rvalid", 32'(scan_rvalid), 0);
        scan_addr = 17'h101;
        tick();
        check("lat a1 mem_addr", 32'(mem_addr), 32'h101);
        check("lat d0 rvalid", 32'(scan_rvalid), 1);
        check("lat d0 rdata", 32'(scan_rdata), 32'(pat(17'h100)));
        scan_req = 1'b0;
        tick();
        check("lat d1 rvalid", 32'(scan_rvalid), 1);
        check("lat d1 rdata", 32'(scan_rdata), 32'(pat(17'h101)));
        check("lat idle mem_en", 32'(mem_en), 0);
        tick();
        check("lat end rvalid", 32'(scan_rvalid), 0);
        check("lat end rdata", 32'(scan_rdata), 0);

        // Starvation: one word stuck behind continuous scan.
        do_reset();
        scan_req  = 1'b1;
        scan_addr = 17'h10;
        wr_valid  = 1'b1;
        wr_addr   = 17'h4000;
        wr_data   = 8'h11;
        tick();
        wr_valid = 1'b0;
        check("stv level", 32'(wbuf_level), 1);
        repeat (LIMIT - 1) tick();
        check("stv before limit", 32'(starve_err), 0);
        tick();
        check("stv at limit", 32'(starve_err), 1);
        scan_req = 1'b0;
        tick();
        check("stv drain we", 32'(mem_we), 1);
        check("stv drain addr", 32'(mem_addr), 32'h4000);
        check("stv drain data", 32'(mem_wdata), 32'h11);
        check("stv sticky", 32'(starve_err), 1);
        repeat (3) tick();
        check("stv sticky idle", 32'(starve_err), 1);
        do_reset();
        check("stv cleared", 32'(starve_err), 0);

        // Reset with level 5 and a scan read in flight.
        scan_req  = 1'b1;
        scan_addr = 17'h20;
        wr_valid  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_addr = 17'h5000 + 17'(i);
            wr_data = 8'hD0 + 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        scan_req = 1'b0;
        tick();
        tick();
        check("mid level", 32'(wbuf_level), 5);
        scan_req  = 1'b1;
        scan_addr = 17'h200;
        tick();
        check("mid scan en", 32'(mem_en), 1);
        scan_req = 1'b0;
        reset    = 1'b1;
        tick();
        check("mid rst mem_en", 32'(mem_en), 0);
        check("mid rst level", 32'(wbuf_level), 0);
        check("mid rst rvalid", 32'(scan_rvalid), 0);
        check("mid rst wr_ready", 32'(wr_ready), 0);
        reset = 1'b0;
        #1;
        check("mid post wr_ready", 32'(wr_ready), 1);
        tick();
        check("mid post mem_en", 32'(mem_en), 0);
        check("mid post rvalid", 32'(scan_rvalid), 0);
        check("mid post level", 32'(wbuf_level), 0);
        wr_valid = 1'b1;
        wr_addr  = 17'h6000;
        wr_data  = 8'hEE;
        tick();
        wr_valid = 1'b0;
        tick();
        check("mid fresh we", 32'(mem_we), 1);
        check("mid fresh addr", 32'(mem_addr), 32'h6000);
        check("mid fresh data", 32'(mem_wdata), 32'hEE);
        tick();
        check("mid fresh level", 32'(wbuf_level), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
